// File: rtl/axi_default_slave.sv
// ============================================================================
// axi_default_slave
// ----------------------------------------------------------------------------
// Purpose:
//   Terminates AXI transactions whose address matched no mapped slave region
//   (the decoder's VALID_SDEFAULT / READY_SDEFAULT leg). Every write is
//   answered with a single DECERR B response once WLAST has been seen. Every
//   read is answered with ARLEN+1 beats of zero data carrying DECERR.
//   The read and write channels each have their own state machine and run
//   fully concurrently.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   AW*                  write address (AWLEN ignored, WLAST ends the burst)
//   W*                   write data (accepted and discarded)
//   B*                   write response (BRESP always 2'b11)
//   AR*                  read address
//   R*                   read data (RDATA always 0, RRESP always 2'b11)
//   ERR_CNT[15:0]        saturating count of accepted AW+AR handshakes,
//                        present only when AXI_DEFAULT_SLAVE_ERRCNT_EN is
//                        defined
//
// Configuration macro:
//   AXI_DEFAULT_SLAVE_ERRCNT_EN  - adds the ERR_CNT output and its counter.
//
// All handshake outputs decode from registered state only, so there is no
// combinational path from any input to any output.
// ============================================================================
`timescale 1ns/1ps

module axi_default_slave #(
    parameter int ID_W   = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    // write address
    input  logic [ID_W-1:0]   AWID,
    input  logic [LEN_W-1:0]  AWLEN,
    input  logic              AWVALID,
    output logic              AWREADY,
    // write data
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    // write response
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    // read address
    input  logic [ID_W-1:0]   ARID,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic              ARVALID,
    output logic              ARREADY,
    // read data
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY
`ifdef AXI_DEFAULT_SLAVE_ERRCNT_EN
    ,
    output logic [15:0]       ERR_CNT
`endif
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    logic [ID_W-1:0]   bid_q,     bid_d;
    logic [ID_W-1:0]   rid_q,     rid_d;
    logic [LEN_W-1:0]  rlen_q,    rlen_d;
    logic [LEN_W-1:0]  rcnt_q,    rcnt_d;

    // Write data and the write burst length carry no information for an
    // error responder; they are deliberately dropped.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, AWLEN, WDATA};

    // ------------------------------------------------------------------
    // Output decode (registered state only)
    // ------------------------------------------------------------------
    assign AWREADY = (w_state_q == W_IDLE);
    assign WREADY  = (w_state_q == W_DATA);
    assign BVALID  = (w_state_q == W_RESP);
    assign BID     = bid_q;
    assign BRESP   = 2'b11;

    assign ARREADY = (r_state_q == R_IDLE);
    assign RVALID  = (r_state_q == R_DATA);
    // The counter stops at the captured length, so LEN=15 gives exactly
    // 16 beats without the counter ever wrapping.
    assign RLAST   = (r_state_q == R_DATA) && (rcnt_q == rlen_q);
    assign RID     = rid_q;
    assign RDATA   = '0;
    assign RRESP   = 2'b11;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID) begin
                    bid_d     = AWID;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                // No beat limit: only WLAST ends the burst.
                if (WVALID && WLAST) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID) begin
                    rid_d     = ARID;
                    rlen_d    = ARLEN;
                    rcnt_d    = '0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    if (RLAST) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bid_q     <= '0;
            rid_q     <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bid_q     <= bid_d;
            rid_q     <= rid_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
        end
    end

`ifdef AXI_DEFAULT_SLAVE_ERRCNT_EN
    // ------------------------------------------------------------------
    // Saturating error counter: +1 per AW or AR handshake, +2 when both
    // land in the same cycle. The sum is formed one bit wider so a +2 from
    // 16'hFFFE still clamps to 16'hFFFF.
    // ------------------------------------------------------------------
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        aw_hs, ar_hs;
    logic [16:0] err_sum;

    assign aw_hs   = AWVALID && AWREADY;
    assign ar_hs   = ARVALID && ARREADY;
    assign err_sum = {1'b0, err_cnt_q} + {16'd0, aw_hs} + {16'd0, ar_hs};

    always_comb begin
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi_default_slave.sv
// ============================================================================
// tb_axi_default_slave
// ----------------------------------------------------------------------------
// Self-checking bench for axi_default_slave. A per-cycle vector table drives
// inputs on the falling edge and checks the outputs for that cycle right
// after. Hand-written sequences then cover reset in the middle of a read
// burst and a single-beat read after it.
// ============================================================================
`timescale 1ns/1ps

module tb_axi_default_slave;

    localparam int ID_W   = 8;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int NVEC   = 25;

    logic              clk;
    logic              rst;
    logic [ID_W-1:0]   awid;
    logic [LEN_W-1:0]  awlen;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   arid;
    logic [LEN_W-1:0]  arlen;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
`ifdef AXI_DEFAULT_SLAVE_ERRCNT_EN
    logic [15:0]       err_cnt;
`endif

    axi_default_slave #(
        .ID_W   (ID_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .AWID    (awid),
        .AWLEN   (awlen),
        .AWVALID (awvalid),
        .AWREADY (awready),
        .WDATA   (wdata),
        .WLAST   (wlast),
        .WVALID  (wvalid),
        .WREADY  (wready),
        .BID     (bid),
        .BRESP   (bresp),
        .BVALID  (bvalid),
        .BREADY  (bready),
        .ARID    (arid),
        .ARLEN   (arlen),
        .ARVALID (arvalid),
        .ARREADY (arready),
        .RID     (rid),
        .RDATA   (rdata),
        .RRESP   (rresp),
        .RLAST   (rlast),
        .RVALID  (rvalid),
        .RREADY  (rready)
`ifdef AXI_DEFAULT_SLAVE_ERRCNT_EN
        ,
        .ERR_CNT (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        // inputs applied during the cycle
        logic             awvalid;
        logic [7:0]       awid;
        logic             wvalid;
        logic             wlast;
        logic             bready;
        logic             arvalid;
        logic [7:0]       arid;
        logic [3:0]       arlen;
        logic             rready;
        // outputs expected during the same cycle
        logic             e_awready;
        logic             e_wready;
        logic             e_bvalid;
        logic [7:0]       e_bid;
        logic             e_arready;
        logic             e_rvalid;
        logic             e_rlast;
        logic [7:0]       e_rid;
        logic [15:0]      e_cnt;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic awv, input logic [7:0] aid, input logic wv, input logic wl,
        input logic br, input logic arv, input logic [7:0] rdid, input logic [3:0] rlen,
        input logic rr,
        input logic eaw, input logic ew, input logic eb, input logic [7:0] ebid,
        input logic ear, input logic erv, input logic erl, input logic [7:0] erid,
        input logic [15:0] ecnt);
        vec_t v;
        v.awvalid = awv;  v.awid = aid;   v.wvalid = wv;   v.wlast = wl;
        v.bready = br;    v.arvalid = arv; v.arid = rdid;  v.arlen = rlen;
        v.rready = rr;
        v.e_awready = eaw; v.e_wready = ew; v.e_bvalid = eb; v.e_bid = ebid;
        v.e_arready = ear; v.e_rvalid = erv; v.e_rlast = erl; v.e_rid = erid;
        v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic idle_inputs();
        awvalid = 0; awid = '0; awlen = '0; wvalid = 0; wlast = 0; wdata = '0;
        bready = 0; arvalid = 0; arid = '0; arlen = '0; rready = 0;
    endtask

    initial begin
        int beats;

        //                 awv aid   wv wl br arv arid  len rr | aw w  b  bid   ar rv rl rid   cnt
        // reset then idle
        vecs[0]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 16'd0);
        // read ARID=25 ARLEN=3, RREADY high: 4 beats, RLAST on 4th
        vecs[1]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h25, 4'd3, 1,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 16'd0);
        vecs[2]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 1,  1, 0, 0, 8'h00, 0, 1, 0, 8'h25, 16'd1);
        vecs[3]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 1,  1, 0, 0, 8'h00, 0, 1, 0, 8'h25, 16'd1);
        vecs[4]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 1,  1, 0, 0, 8'h00, 0, 1, 0, 8'h25, 16'd1);
        vecs[5]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 1,  1, 0, 0, 8'h00, 0, 1, 1, 8'h25, 16'd1);
        // ARREADY back; new read ARLEN=0, RREADY low for 5 cycles
        vecs[6]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h33, 4'd0, 0,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 16'd1);
        vecs[7]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0,  1, 0, 0, 8'h00, 0, 1, 1, 8'h33, 16'd2);
        vecs[8]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0,  1, 0, 0, 8'h00, 0, 1, 1, 8'h33, 16'd2);
        vecs[9]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0,  1, 0, 0, 8'h00, 0, 1, 1, 8'h33, 16'd2);
        vecs[10] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0,  1, 0, 0, 8'h00, 0, 1, 1, 8'h33, 16'd2);
        vecs[11] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0,  1, 0, 0, 8'h00, 0, 1, 1, 8'h33, 16'd2);
        vecs[12] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 1,  1, 0, 0, 8'h00, 0, 1, 1, 8'h33, 16'd2);
        // write AWID=1A, 3 beats, BREADY low 2 cycles
        vecs[13] = mk(1, 8'h1A, 0, 0, 0, 0, 8'h00, 4'd0, 0,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 16'd2);
        vecs[14] = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 4'd0, 0,  0, 1, 0, 8'h00, 1, 0, 0, 8'h00, 16'd3);
        vecs[15] = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 4'd0, 0,  0, 1, 0, 8'h00, 1, 0, 0, 8'h00, 16'd3);
        vecs[16] = mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 4'd0, 0,  0, 1, 0, 8'h00, 1, 0, 0, 8'h00, 16'd3);
        vecs[17] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0,  0, 0, 1, 8'h1A, 1, 0, 0, 8'h00, 16'd3);
        vecs[18] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0,  0, 0, 1, 8'h1A, 1, 0, 0, 8'h00, 16'd3);
        vecs[19] = mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 4'd0, 0,  0, 0, 1, 8'h1A, 1, 0, 0, 8'h00, 16'd3);
        // W beat offered while idle is not accepted
        vecs[20] = mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 4'd0, 0,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 16'd3);
        // AW and AR in the same cycle; 1 write beat, ARLEN=1
        vecs[21] = mk(1, 8'h5A, 0, 0, 0, 1, 8'hA5, 4'd1, 1,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 16'd3);
        vecs[22] = mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 4'd0, 1,  0, 1, 0, 8'h00, 0, 1, 0, 8'hA5, 16'd5);
        vecs[23] = mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 4'd0, 1,  0, 0, 1, 8'h5A, 0, 1, 1, 8'hA5, 16'd5);
        vecs[24] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0,  1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 16'd5);

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            awvalid = vecs[i].awvalid; awid = vecs[i].awid;
            awlen   = 4'd2;                       // must be ignored
            wvalid  = vecs[i].wvalid;  wlast = vecs[i].wlast;
            wdata   = 32'hDEAD_0000 + 32'(i);     // discarded
            bready  = vecs[i].bready;
            arvalid = vecs[i].arvalid; arid = vecs[i].arid; arlen = vecs[i].arlen;
            rready  = vecs[i].rready;
            #1;
            $display("vec %0d: awready=%0b wready=%0b bvalid=%0b bid=%0h arready=%0b rvalid=%0b rlast=%0b rid=%0h",
                     i, awready, wready, bvalid, bid, arready, rvalid, rlast, rid);
            chk($sformatf("v%0d awready", i), 32'(awready), 32'(vecs[i].e_awready));
            chk($sformatf("v%0d wready", i),  32'(wready),  32'(vecs[i].e_wready));
            chk($sformatf("v%0d bvalid", i),  32'(bvalid),  32'(vecs[i].e_bvalid));
            chk($sformatf("v%0d arready", i), 32'(arready), 32'(vecs[i].e_arready));
            chk($sformatf("v%0d rvalid", i),  32'(rvalid),  32'(vecs[i].e_rvalid));
            chk($sformatf("v%0d rlast", i),   32'(rlast),   32'(vecs[i].e_rlast));
            chk($sformatf("v%0d rdata", i),   rdata,        32'd0);
            chk($sformatf("v%0d bresp", i),   32'(bresp),   32'd3);
            chk($sformatf("v%0d rresp", i),   32'(rresp),   32'd3);
            // IDs are only meaningful with their valid, plus right after reset
            if (vecs[i].e_bvalid || i == 0)
                chk($sformatf("v%0d bid", i), 32'(bid), 32'(vecs[i].e_bid));
            if (vecs[i].e_rvalid || i == 0)
                chk($sformatf("v%0d rid", i), 32'(rid), 32'(vecs[i].e_rid));
`ifdef AXI_DEFAULT_SLAVE_ERRCNT_EN
            chk($sformatf("v%0d err_cnt", i), 32'(err_cnt), 32'(vecs[i].e_cnt));
`endif
        end

        // ---- reset during beat 2 of an ARLEN=7 read ----
        @(negedge clk);
        idle_inputs();
        arvalid = 1; arid = 8'h77; arlen = 4'd7; rready = 1;
        #1 chk("mid arready", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 0;
        #1 $display("mid beat1: rvalid=%0b rlast=%0b rid=%0h", rvalid, rlast, rid);
        chk("mid beat1 rvalid", 32'(rvalid), 32'd1);
        chk("mid beat1 rid", 32'(rid), 32'h77);
        @(negedge clk);
        #1 chk("mid beat2 rlast", 32'(rlast), 32'd0);
        rst = 1'b1;
        #1 $display("mid reset: rvalid=%0b arready=%0b rid=%0h", rvalid, arready, rid);
        chk("rst rvalid", 32'(rvalid), 32'd0);
        chk("rst arready", 32'(arready), 32'd1);
        chk("rst rlast", 32'(rlast), 32'd0);
        chk("rst rid", 32'(rid), 32'd0);
        chk("rst awready", 32'(awready), 32'd1);
`ifdef AXI_DEFAULT_SLAVE_ERRCNT_EN
        chk("rst err_cnt", 32'(err_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        rready = 0; arvalid = 1; arid = 8'h12; arlen = 4'd0;
        #1 chk("post arready", 32'(arready), 32'd1);

        // ---- single-beat read after reset: count beats, bounded ----
        beats = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            arvalid = 0; rready = 1;
            #1;
            if (rvalid) begin
                beats++;
                $display("post beat %0d: rid=%0h rlast=%0b rdata=%0h", beats, rid, rlast, rdata);
                chk("post rlast", 32'(rlast), 32'd1);
                chk("post rid", 32'(rid), 32'h12);
            end
        end
        chk("post beat count", 32'(beats), 32'd1);
        chk("post arready end", 32'(arready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_default_slave.md
Name: axi_default_slave

Overview:
- Terminates every AXI transaction whose address falls outside all mapped slave regions. The interconnect address decoder routes these as its VALID_SDEFAULT / READY_SDEFAULT leg.
- Sits directly downstream of the decoder on the slave side of the interconnect. It completes each such transaction with a DECERR response so a master never hangs on an unmapped address.
- Read and write channels run independent state machines.

Parameters:
- ID_W, 8, slave-side transaction ID width (master ID extended by the interconnect)
- DATA_W, 32, R/W data width
- LEN_W, 4, burst length field width (beats = LEN+1)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- AWID  input  ID_W  write address ID
- AWLEN  input  LEN_W  write burst length (ignored; WLAST terminates the burst)
- AWVALID  input  1  write address valid (decoder VALID_SDEFAULT on AW)
- AWREADY  output  1  write address ready (to decoder READY_SDEFAULT on AW)
- WDATA  input  DATA_W  write data (discarded)
- WLAST  input  1  last write beat
- WVALID  input  1  write data valid
- WREADY  output  1  write data ready
- BID  output  ID_W  write response ID
- BRESP  output  2  write response
- BVALID  output  1  write response valid
- BREADY  input  1  write response ready
- ARID  input  ID_W  read address ID
- ARLEN  input  LEN_W  read burst length
- ARVALID  input  1  read address valid (decoder VALID_SDEFAULT on AR)
- ARREADY  output  1  read address ready
- RID  output  ID_W  read data ID
- RDATA  output  DATA_W  read data, always 0
- RRESP  output  2  read response
- RLAST  output  1  last read beat
- RVALID  output  1  read data valid
- RREADY  input  1  read data ready

Behaviour:
- Reset (async, rst=1): write FSM=W_IDLE, read FSM=R_IDLE; captured IDs, length and beat counter cleared.
  - After reset: AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BID=0, RID=0, RDATA=0.
  - BRESP=RRESP=2'b11 at all times.
- All handshake outputs decode from registered state only; there are no combinational input-to-output paths.

Write FSM:
- W_IDLE: AWREADY=1.
  - AWVALID=1 captures AWID into BID; goes to W_DATA next cycle.
- W_DATA: AWREADY=0, WREADY=1.
  - Each WVALID beat is accepted and discarded.
  - WVALID&&WLAST goes to W_RESP.
  - WVALID without WLAST stays in W_DATA; there is no beat limit.
- W_RESP: WREADY=0, BVALID=1, BRESP=2'b11.
  - BREADY=1 returns to W_IDLE.
  - BVALID holds with stable BID until BREADY=1.
- W beats presented while in W_IDLE are not accepted (WREADY=0).

Read FSM:
- R_IDLE: ARREADY=1.
  - ARVALID=1 captures ARID and ARLEN, clears beat counter, goes to R_DATA.
- R_DATA: ARREADY=0, RVALID=1, RDATA=0, RRESP=2'b11, RID=captured ID.
  - RLAST=1 iff counter==captured LEN.
  - RVALID&&RREADY with RLAST=0 increments the counter.
  - RVALID&&RREADY with RLAST=1 returns to R_IDLE.
  - RREADY=0 holds all R outputs stable.
- Beat counter is LEN_W bits and never wraps: the maximum LEN (15) gives exactly 16 beats.

Timing and concurrency:
- Latency: AR accepted cycle N → first RVALID cycle N+1.
- Latency: last W beat cycle M → BVALID cycle M+1.
- Latency: B handshake cycle K → AWREADY=1 cycle K+1. The same applies for R last beat → ARREADY.
- Read and write channels are fully concurrent. Simultaneous AR and AW acceptance in one cycle is legal and independent.
- Reset asserted mid-burst aborts immediately to the reset state. No response is issued for the aborted transaction.

Optional Feature:
- Macro: AXI_DEFAULT_SLAVE_ERRCNT_EN.
- Defined:
  - Adds output port ERR_CNT[15:0], reset to 0.
  - Increments by 1 per accepted AW or AR handshake, and by 2 when both handshakes occur in the same cycle.
  - Saturates at 16'hFFFF, including from 16'hFFFE with a double increment.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle → AWREADY=1, ARREADY=1, BVALID=0, RVALID=0, RDATA=0.
- AR with ARID=8'h25, ARLEN=3, RREADY=1 → four RVALID beats starting the cycle after AR; RID=8'h25, RRESP=2'b11, RDATA=0; RLAST only on the 4th beat; ARREADY=1 the cycle after.
- AR with ARLEN=0 and RREADY held low 5 cycles → RVALID=1, RLAST=1 stable for all 5 cycles; completes on the first RREADY=1.
- AW with AWID=8'h1A, then 3 W beats with WLAST on the 3rd, BREADY=0 for 2 cycles → BVALID appears the cycle after the 3rd beat; BID=8'h1A, BRESP=2'b11 held until BREADY=1.
- AW and AR in the same cycle, write 1 beat, read ARLEN=1 → both complete independently with correct IDs. With AXI_DEFAULT_SLAVE_ERRCNT_EN defined, ERR_CNT goes 0→2 in one cycle.
- rst asserted during beat 2 of an ARLEN=7 read → RVALID=0, ARREADY=1 immediately. A following ARLEN=0 read returns exactly one beat with RLAST=1.
